mvm_uart_host: RTL and testbench

- Host-side initiator for the UART matrix-vector multiply link.
- Accepts one flattened K/X operand bus on a valid/ready slave port and serializes it onto tx as UART bytes, lowest byte first.
- Receives the R sign-extended W_Y_OUT-bit results on rx, reassembles them, and presents them on a valid/ready master port.
- Used as the FPGA-side traffic generator and as the bench driver for the MVM UART system.

---
 rtl/mvm_uart_host.sv | 234 +++++++++++++++++++++++
 tb/tb_mvm_uart_host.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_uart_host.sv
// Host-side UART initiator for the MVM link: serializes the K/X operand bus onto tx and
// reassembles result bytes from rx. Optional response timeout: define MVM_HOST_TIMEOUT_EN.
module mvm_uart_host #(
    parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int BITS_PER_WORD    = 8,
    parameter int PACKET_SIZE_TX   = BITS_PER_WORD + 2,
    parameter int R                = 8,
    parameter int C                = 8,
    parameter int W_X              = 8,
    parameter int W_K              = 8,
    parameter int W_Y_OUT          = 32,
    parameter int TIMEOUT_PULSES   = 64,
    localparam int W_BUS_KX        = R * C * W_K + C * W_X,
    localparam int W_BUS_Y         = R * W_Y_OUT
) (
    input  logic                clk,
    input  logic                rstn,
    // Both ports: a beat transfers on a rising edge where valid && ready are both high;
    // the source holds valid and its payload stable until that edge.
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [W_BUS_KX-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [W_BUS_Y-1:0]  m_data,
    output logic                tx,
    input  logic                rx,
    output logic                err,
    output logic [1:0]          dbg_state,
    output logic [2:0]          dbg_rx_state
);

    localparam int N_TX      = (W_BUS_KX + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int N_RX      = (W_BUS_Y + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int W_TXB     = N_TX * BITS_PER_WORD;
    localparam int W_RXB     = N_RX * BITS_PER_WORD;
    localparam int CW        = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int HALF      = (CLOCKS_PER_PULSE / 2 > 0) ? CLOCKS_PER_PULSE / 2 : 1;
    localparam int TX_BIT_W  = $clog2(PACKET_SIZE_TX);
    localparam int TX_BYTE_W = $clog2(N_TX + 1);
    localparam int RX_BIT_W  = $clog2(BITS_PER_WORD);
    localparam int RX_IDX_W  = $clog2(N_RX + 1);
    localparam int N_STOP    = PACKET_SIZE_TX - 1 - BITS_PER_WORD;
    localparam int FSW       = PACKET_SIZE_TX - 1;
    localparam logic [N_STOP-1:0] STOP_ONES = '1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, HOLD} state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    state_t                state;
    rx_state_t             rx_state;
    logic [W_TXB-1:0]      s_pad;
    logic [W_TXB-1:0]      tx_buf;
    logic [FSW-1:0]        frame_sh;
    logic [CW-1:0]         tx_clk;
    logic [TX_BIT_W-1:0]   tx_bit;
    logic [TX_BYTE_W-1:0]  tx_byte;
    logic [W_RXB-1:0]      y_buf;
    logic [RX_IDX_W-1:0]   rx_idx;
    logic                  rx_q1, rx_q2;
    logic [CW-1:0]         rx_cnt;
    logic [RX_BIT_W-1:0]   rx_bits;
    logic [BITS_PER_WORD-1:0] rx_sh;
    logic                  rx_done, rx_ferr, timeout;

    assign s_pad        = W_TXB'(s_data);
    assign m_data       = y_buf[W_BUS_Y-1:0];
    assign dbg_state    = state;
    assign dbg_rx_state = rx_state;
    assign rx_done = (rx_state == RX_STOP) && (rx_cnt == CW'(CLOCKS_PER_PULSE - 1)) && rx_q2;
    assign rx_ferr = (rx_state == RX_STOP) && (rx_cnt == CW'(CLOCKS_PER_PULSE - 1)) && !rx_q2;

`ifdef MVM_HOST_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_PULSES + 1);
    logic [CW-1:0]  to_clk;
    logic [TOW-1:0] to_pulse;

    assign timeout = (state == WAIT_RESP) && (rx_state == RX_IDLE)
                     && (to_clk == CW'(CLOCKS_PER_PULSE - 1))
                     && (to_pulse == TOW'(TIMEOUT_PULSES - 1));

    // Bit periods of silence; any receiver activity or a fresh byte restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_clk   <= '0;
            to_pulse <= '0;
        end else if (state != WAIT_RESP || rx_state != RX_IDLE) begin
            to_clk   <= '0;
            to_pulse <= '0;
        end else if (to_clk == CW'(CLOCKS_PER_PULSE - 1)) begin
            to_clk   <= '0;
            to_pulse <= to_pulse + 1'b1;
        end else begin
            to_clk <= to_clk + 1'b1;
        end
    end
`else
    // Without the counter the link waits for the response indefinitely.
    assign timeout = (TIMEOUT_PULSES < 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_q1    <= 1'b1;
            rx_q2    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_sh    <= '0;
        end else begin
            rx_q1 <= rx;
            rx_q2 <= rx_q1;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_q2) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == CW'(HALF - 1)) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_q2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_q2, rx_sh[BITS_PER_WORD-1:1]};
                        if (rx_bits == RX_BIT_W'(BITS_PER_WORD - 1)) rx_state <= RX_STOP;
                        else rx_bits <= rx_bits + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_q2 ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: if (rx_q2) rx_state <= RX_IDLE;
                default:      rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            s_ready  <= 1'b1;
            m_valid  <= 1'b0;
            y_buf    <= '0;
            tx       <= 1'b1;
            err      <= 1'b0;
            tx_buf   <= '0;
            frame_sh <= '1;
            tx_clk   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            rx_idx   <= '0;
        end else begin
            err <= rx_ferr | timeout;
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        tx_buf   <= s_pad >> BITS_PER_WORD;
                        frame_sh <= {STOP_ONES, s_pad[BITS_PER_WORD-1:0]};
                        tx       <= 1'b0;
                        tx_clk   <= '0;
                        tx_bit   <= '0;
                        tx_byte  <= '0;
                        s_ready  <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_clk == CW'(CLOCKS_PER_PULSE - 1)) begin
                        tx_clk <= '0;
                        if (tx_bit == TX_BIT_W'(PACKET_SIZE_TX - 1)) begin
                            tx_bit <= '0;
                            if (tx_byte == TX_BYTE_W'(N_TX - 1)) begin
                                tx     <= 1'b1;
                                rx_idx <= '0;
                                state  <= WAIT_RESP;
                            end else begin
                                tx_byte  <= tx_byte + 1'b1;
                                tx       <= 1'b0;
                                frame_sh <= {STOP_ONES, tx_buf[BITS_PER_WORD-1:0]};
                                tx_buf   <= tx_buf >> BITS_PER_WORD;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx       <= frame_sh[0];
                            frame_sh <= {1'b1, frame_sh[FSW-1:1]};
                        end
                    end else begin
                        tx_clk <= tx_clk + 1'b1;
                    end
                end
                WAIT_RESP: begin
                    if (timeout) begin
                        y_buf   <= '0;
                        s_ready <= 1'b1;
                        state   <= IDLE;
                    end else if (rx_done) begin
                        // Bytes shift down from the top so the first one lands in the LSBs.
                        y_buf <= {rx_sh, y_buf[W_RXB-1:BITS_PER_WORD]};
                        if (rx_idx == RX_IDX_W'(N_RX - 1)) begin
                            m_valid <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_uart_host.sv
// Self-checking bench for mvm_uart_host with a 4-cycle bit period and a 2x2 matrix.
module tb_mvm_uart_host;

    localparam int CPP   = 4;
    localparam int BPW   = 8;
    localparam int FRAME = 10;
    localparam int W_KX  = 48;
    localparam int W_BY  = 64;
    localparam int N_TX  = 6;
    localparam int N_RX  = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic            clk = 1'b0;
    logic            rstn, s_valid, s_ready, m_valid, m_ready, tx, rx, err;
    logic [W_KX-1:0] s_data;
    logic [W_BY-1:0] m_data;
    logic [1:0]      dbg_state;
    logic [2:0]      dbg_rx_state;

    int checks  = 0;
    int errors  = 0;
    int err_cnt = 0;
    int mv_cnt  = 0;
    logic [7:0]      exp_q[$];
    logic [7:0]      rsp[N_RX];
    logic [W_BY-1:0] exp_y;

    mvm_uart_host #(
        .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW), .PACKET_SIZE_TX(FRAME),
        .R(2), .C(2), .W_X(8), .W_K(8), .W_Y_OUT(32), .TIMEOUT_PULSES(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .tx(tx), .rx(rx), .err(err),
        .dbg_state(dbg_state), .dbg_rx_state(dbg_rx_state)
    );

    always #5 clk = ~clk;

    // Every wait goes through tick, so err and m_valid are sampled on every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (err === 1'b1) err_cnt++;
        if (m_valid === 1'b1) mv_cnt++;
    endtask

    task automatic fill_rsp(input logic random_bytes, input logic [7:0] base);
        exp_y = '0;
        for (int i = 0; i < N_RX; i++) begin
            rsp[i] = random_bytes ? 8'($urandom_range(0, 255)) : base + 8'(i);
            exp_y  = exp_y | (W_BY'(rsp[i]) << (8 * i));
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPP) tick();
        for (int i = 0; i < BPW; i++) begin
            rx = b[i];
            repeat (CPP) tick();
        end
        rx = stop_bit;
        repeat (CPP) tick();
        rx = 1'b1;
    endtask

    task automatic send_rsp_bytes(input int first, input int last_excl);
        for (int i = first; i < last_excl; i++) drive_rx(rsp[i], 1'b1);
    endtask

    task automatic do_send(input logic [W_KX-1:0] data);
        logic [7:0] cur;
        logic       exp_bit;
        int         k;
        for (int j = 0; j < N_TX; j++) exp_q.push_back(8'(data >> (8 * j)));
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL send_ready_idle: got %b want 1", s_ready);
        end
        s_data  = data;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL send_ready_drop: got %b want 0", s_ready);
        end
        cur = '0;
        for (int c = 0; c < N_TX * FRAME * CPP; c++) begin
            if (c % (FRAME * CPP) == 0) cur = exp_q.pop_front();
            k = (c % (FRAME * CPP)) / CPP;
            if (k == 0) exp_bit = 1'b0;
            else if (k <= BPW) exp_bit = cur[k-1];
            else exp_bit = 1'b1;
            checks++;
            if (tx !== exp_bit) begin
                errors++;
                $display("FAIL tx_bit cycle %0d frame %0d bit %0d: got %b want %b",
                         c, c / (FRAME * CPP), k, tx, exp_bit);
            end
            tick();
        end
        checks++;
        if (tx !== 1'b1 || dbg_state !== ST_WAIT) begin
            errors++; $display("FAIL send_done: tx %b state %0d want tx 1 state %0d", tx, dbg_state, ST_WAIT);
        end
    endtask

    task automatic check_result(input string name);
        int n = 0;
        while (m_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++; $display("FAIL %s_valid_timeout: m_valid %b after %0d cycles want 1", name, m_valid, n);
        end
        checks++;
        if (m_data !== exp_y) begin
            errors++; $display("FAIL %s_data: got %h want %h", name, m_data, exp_y);
        end
        checks++;
        if (dbg_state !== ST_HOLD) begin
            errors++; $display("FAIL %s_state: got %0d want %0d", name, dbg_state, ST_HOLD);
        end
    endtask

    task automatic receive_all(input string name);
        send_rsp_bytes(0, N_RX - 1);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL %s_early_valid: got %b want 0", name, m_valid);
        end
        send_rsp_bytes(N_RX - 1, N_RX);
        check_result(name);
    endtask

    task automatic handshake(input string name);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL %s_handshake: m_valid %b s_ready %b state %0d want 0 1 %0d",
                     name, m_valid, s_ready, dbg_state, ST_IDLE);
        end
    endtask

    function automatic logic [W_KX-1:0] rand_kx();
        logic [W_KX-1:0] d;
        d[31:0]  = $urandom();
        d[47:32] = 16'($urandom());
        return d;
    endfunction

    task automatic test_reset();
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; rx = 1'b1;
        repeat (3) tick();
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++;
        if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_send(48'h0605_0403_0201);
        fill_rsp(1'b0, 8'h11);
        receive_all("basic");
    endtask

    task automatic test_hold();
        drive_rx(8'h5A, 1'b1);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_y) begin
                errors++; $display("FAIL hold_stable cycle %0d: valid %b data %h want 1 %h", i, m_valid, m_data, exp_y);
            end
            tick();
        end
        handshake("hold");
    endtask

    task automatic test_glitch_framing();
        int base;
        fill_rsp(1'b1, 8'h00);
        do_send(rand_kx());
        send_rsp_bytes(0, 2);
        base = err_cnt;
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (10) tick();
        checks++;
        if (err_cnt != base) begin errors++; $display("FAIL glitch_err: got %0d pulses want 0", err_cnt - base); end
        drive_rx(8'hAA, 1'b0);
        repeat (6) tick();
        checks++;
        if (err_cnt != base + 1) begin errors++; $display("FAIL framing_err: got %0d pulses want 1", err_cnt - base); end
        send_rsp_bytes(2, N_RX - 1);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL framing_early_valid: got %b want 0", m_valid); end
        send_rsp_bytes(N_RX - 1, N_RX);
        check_result("framing");
        handshake("framing");
    endtask

    task automatic test_reset_mid_frame();
        s_data  = rand_kx();
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (50) tick();
        rstn = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || s_ready !== 1'b1 || m_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset: tx %b s_ready %b m_valid %b state %0d want 1 1 0 %0d",
                     tx, s_ready, m_valid, dbg_state, ST_IDLE);
        end
        tick();
        rstn = 1'b1;
        tick();
        fill_rsp(1'b1, 8'h00);
        do_send(rand_kx());
        receive_all("midreset");
        handshake("midreset");
    endtask

    task automatic test_timeout();
        int base;
        int mvb;
        int n;
        fill_rsp(1'b1, 8'h00);
        do_send(rand_kx());
        send_rsp_bytes(0, 3);
        base = err_cnt;
        mvb  = mv_cnt;
`ifdef MVM_HOST_TIMEOUT_EN
        n = 0;
        while (err_cnt == base && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n < 62 || n > 68) begin errors++; $display("FAIL timeout_delay: got %0d cycles want 62..68", n); end
        checks++;
        if (dbg_state !== ST_IDLE || s_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_idle: state %0d s_ready %b want %0d 1", dbg_state, s_ready, ST_IDLE);
        end
        checks++;
        if (m_data !== '0) begin errors++; $display("FAIL timeout_clear: got %h want 0", m_data); end
        repeat (4) tick();
        checks++;
        if (mv_cnt != mvb) begin errors++; $display("FAIL timeout_no_valid: got %0d valid cycles want 0", mv_cnt - mvb); end
`else
        n = 100;
        repeat (n) tick();
        checks++;
        if (err_cnt != base || dbg_state !== ST_WAIT) begin
            errors++; $display("FAIL no_timeout: err pulses %0d state %0d want 0 %0d", err_cnt - base, dbg_state, ST_WAIT);
        end
        send_rsp_bytes(3, N_RX);
        check_result("late");
        checks++;
        if (mv_cnt == mvb) begin errors++; $display("FAIL late_valid: got 0 valid cycles want >0"); end
        handshake("late");
`endif
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 3; it++) begin
            drive_rx(8'($urandom_range(0, 255)), 1'b1);
            repeat (2) tick();
            fill_rsp(1'b1, 8'h00);
            m_ready = 1'b1;
            do_send(rand_kx());
            receive_all("b2b");
            tick();
            m_ready = 1'b0;
            checks++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_release %0d: m_valid %b s_ready %b want 0 1", it, m_valid, s_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_glitch_framing();
        test_reset_mid_frame();
        test_timeout();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
